// File: rtl/router_pkg.sv
// Shared definitions for the XY mesh router: port indices, header field offsets, RR helper.
package router_pkg;

  localparam int unsigned NUM_PORTS = 5;

  localparam logic [2:0] P_E  = 3'd0;
  localparam logic [2:0] P_W  = 3'd1;
  localparam logic [2:0] P_S  = 3'd2;
  localparam logic [2:0] P_N  = 3'd3;
  localparam logic [2:0] P_PE = 3'd4;

  // Bit offset of the destination X field within a flit.
  function automatic int unsigned dst_x_lsb();
    return 0;
  endfunction

  // Bit offset of the destination Y field within a flit.
  function automatic int unsigned dst_y_lsb(input int unsigned coord_w);
    return coord_w;
  endfunction

  // Next port index in round-robin order, wrapping after the PE port.
  function automatic logic [2:0] next_port(input logic [2:0] p);
    return (p == P_PE) ? P_E : p + 3'd1;
  endfunction

endpackage

// File: rtl/router_in_fifo.sv
// First-word-fall-through input FIFO; head is visible the cycle after the write.
module router_in_fifo #(
  parameter int unsigned DATA_W     = 64,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_wr_en,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_rd_en,
  output logic [DATA_W-1:0] o_rd_data,
  output logic              o_full,
  output logic              o_empty
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]     r_wptr;
  logic [AW-1:0]     r_rptr;
  logic [AW:0]       r_cnt;
  logic              w_push;
  logic              w_pop;

  assign o_full    = (r_cnt == (AW+1)'(FIFO_DEPTH));
  assign o_empty   = (r_cnt == '0);
  assign w_push    = i_wr_en & ~o_full;
  assign w_pop     = i_rd_en & ~o_empty;
  assign o_rd_data = r_mem[r_rptr];

  // Storage array; contents are don't-care while empty so no reset is needed.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_wr_data;
  end

  // Pointers wrap naturally (depth is a power of 2); occupancy holds on push+pop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      unique case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/router_xy_param.sv
// Five-port XY mesh router tile: input FIFOs, XY routing, RR arbiters, registered outputs.
module router_xy_param
  import router_pkg::*;
#(
  parameter int unsigned DATA_W     = 64,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned COORD_W    = 4,
  parameter int unsigned MY_X       = 0,
  parameter int unsigned MY_Y       = 0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_PORTS-1:0]          si,
  output logic [NUM_PORTS-1:0]          ri,
  input  logic [NUM_PORTS*DATA_W-1:0]   packet_in,
  output logic [NUM_PORTS-1:0]          so,
  input  logic [NUM_PORTS-1:0]          ro,
  output logic [NUM_PORTS*DATA_W-1:0]   packet_out,
  output logic                          polarity,
  output logic [15:0]                   drop_cnt
);

  localparam int unsigned        XL   = dst_x_lsb();
  localparam int unsigned        YL   = dst_y_lsb(COORD_W);
  localparam logic [COORD_W-1:0] LC_X = COORD_W'(MY_X);
  localparam logic [COORD_W-1:0] LC_Y = COORD_W'(MY_Y);

  logic [DATA_W-1:0]    w_head  [NUM_PORTS];
  logic [2:0]           w_route [NUM_PORTS];
  logic [NUM_PORTS-1:0] w_req   [NUM_PORTS];  // w_req[out][in]
  logic [2:0]           w_gidx  [NUM_PORTS];
  logic [NUM_PORTS-1:0] w_gvld;
  logic [NUM_PORTS-1:0] w_full;
  logic [NUM_PORTS-1:0] w_empty;
  logic [NUM_PORTS-1:0] w_wr;
  logic [NUM_PORTS-1:0] w_pop;
  logic [NUM_PORTS-1:0] w_drop;
  logic [NUM_PORTS-1:0] w_can_load;
  logic [2:0]           w_drop_n;
  logic [16:0]          w_drop_sum;

  logic [2:0]           r_ptr  [NUM_PORTS];
  logic [DATA_W-1:0]    r_data [NUM_PORTS];
  logic [NUM_PORTS-1:0] r_so;
  logic                 r_pol;
  logic [15:0]          r_drop_cnt;

  assign ri         = ~w_full;
  assign w_wr       = si & ~w_full;
  assign so         = r_so;
  assign w_can_load = ~r_so | ro;
  assign polarity   = r_pol;
  assign drop_cnt   = r_drop_cnt;

  for (genvar k = 0; k < NUM_PORTS; k++) begin : g_port
    router_in_fifo #(
      .DATA_W     (DATA_W),
      .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk        (clk),
      .reset      (reset),
      .i_wr_en    (w_wr[k]),
      .i_wr_data  (packet_in[k*DATA_W +: DATA_W]),
      .i_rd_en    (w_pop[k]),
      .o_rd_data  (w_head[k]),
      .o_full     (w_full[k]),
      .o_empty    (w_empty[k])
    );

    assign packet_out[k*DATA_W +: DATA_W] = r_data[k];

    // Dimension-ordered route of the FIFO head: resolve X first, then Y, else local PE.
    always_comb begin
      w_route[k] = P_PE;
      if (w_head[k][XL +: COORD_W] > LC_X)      w_route[k] = P_E;
      else if (w_head[k][XL +: COORD_W] < LC_X) w_route[k] = P_W;
      else if (w_head[k][YL +: COORD_W] > LC_Y) w_route[k] = P_N;
      else if (w_head[k][YL +: COORD_W] < LC_Y) w_route[k] = P_S;
    end

    // A head routed back out of its own port is a U-turn and gets discarded.
    assign w_drop[k] = ~w_empty[k] & (w_route[k] == 3'(k));
  end

  // Request matrix; U-turns never raise a request.
  always_comb begin
    for (int o = 0; o < NUM_PORTS; o++) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        w_req[o][i] = ~w_empty[i] & (w_route[i] == 3'(o)) & (o != i);
      end
    end
  end

  // Round-robin search from ptr+1; grant only when the output register can load.
  always_comb begin
    logic [2:0] idx;
    for (int o = 0; o < NUM_PORTS; o++) begin
      w_gvld[o] = 1'b0;
      w_gidx[o] = r_ptr[o];
      idx       = next_port(r_ptr[o]);
      for (int n = 0; n < NUM_PORTS; n++) begin
        if (w_can_load[o] && !w_gvld[o] && w_req[o][idx]) begin
          w_gvld[o] = 1'b1;
          w_gidx[o] = idx;
        end
        idx = next_port(idx);
      end
    end
  end

  // Pop every granted input and every dropped U-turn head.
  always_comb begin
    w_pop = w_drop;
    for (int o = 0; o < NUM_PORTS; o++) begin
      if (w_gvld[o]) w_pop[w_gidx[o]] = 1'b1;
    end
  end

  // Count of drops this cycle, used for a saturating add.
  always_comb begin
    w_drop_n = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      w_drop_n = w_drop_n + {2'b00, w_drop[k]};
    end
    w_drop_sum = {1'b0, r_drop_cnt} + 17'(w_drop_n);
  end

  // Output registers and RR pointers; pointers reset to PE so port E wins first.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_so <= '0;
      for (int o = 0; o < NUM_PORTS; o++) begin
        r_data[o] <= '0;
        r_ptr[o]  <= P_PE;
      end
    end else begin
      for (int o = 0; o < NUM_PORTS; o++) begin
        if (w_can_load[o]) begin
          r_so[o] <= w_gvld[o];
          if (w_gvld[o]) begin
            r_data[o] <= w_head[w_gidx[o]];
            r_ptr[o]  <= w_gidx[o];
          end
        end
      end
    end
  end

  // Free-running phase bit and saturating drop counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pol      <= 1'b0;
      r_drop_cnt <= '0;
    end else begin
      r_pol      <= ~r_pol;
      r_drop_cnt <= w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
    end
  end

endmodule

// File: tb/tb_router_xy_param.sv
// Scoreboard bench for router_xy_param at tile (1,1); a second DUT uses FIFO_DEPTH=8.
module tb_router_xy_param;

  localparam int DW = 64;

  logic            clk = 1'b0;
  logic            reset;
  logic [4:0]      si, ri, so, ro;
  logic [5*DW-1:0] pin, pout;
  logic            pol;
  logic [15:0]     dcnt;
  logic [4:0]      si8, ri8, so8, ro8;
  logic [5*DW-1:0] pin8, pout8;
  logic            pol8;
  logic [15:0]     dcnt8;

  int          n_total = 0;
  int          n_bad   = 0;
  logic [63:0] q  [5][$];
  logic [63:0] q8 [$];

  always #5 clk = ~clk;

  router_xy_param #(
    .DATA_W(64), .FIFO_DEPTH(4), .COORD_W(4), .MY_X(1), .MY_Y(1)
  ) dut (
    .clk(clk), .reset(reset), .si(si), .ri(ri), .packet_in(pin), .so(so), .ro(ro),
    .packet_out(pout), .polarity(pol), .drop_cnt(dcnt)
  );

  router_xy_param #(
    .DATA_W(64), .FIFO_DEPTH(8), .COORD_W(4), .MY_X(1), .MY_Y(1)
  ) dut8 (
    .clk(clk), .reset(reset), .si(si8), .ri(ri8), .packet_in(pin8), .so(so8), .ro(ro8),
    .packet_out(pout8), .polarity(pol8), .drop_cnt(dcnt8)
  );

  function automatic logic [63:0] mk(input logic [3:0] x, input logic [3:0] y,
                                     input logic [55:0] tag);
    return {tag, y, x};
  endfunction

  function automatic int pending();
    int s = q8.size();
    for (int o = 0; o < 5; o++) s += q[o].size();
    return s;
  endfunction

  // One clock: score any output transfer happening at the coming edge, then step past it.
  task automatic tick();
    logic [63:0] e;
    @(negedge clk);
    for (int o = 0; o < 5; o++) begin
      if (so[o] && ro[o]) begin
        n_total++;
        if (q[o].size() == 0) begin
          n_bad++;
          $display("FAIL sb_out%0d: got unexpected flit %h, wanted none", o, pout[o*DW +: DW]);
        end else begin
          e = q[o].pop_front();
          if (pout[o*DW +: DW] !== e) begin
            n_bad++;
            $display("FAIL sb_out%0d: got %h wanted %h", o, pout[o*DW +: DW], e);
          end
        end
      end
      if (so8[o] && ro8[o]) begin
        n_total++;
        if (o != 4 || q8.size() == 0) begin
          n_bad++;
          $display("FAIL sb8_out%0d: got unexpected flit %h", o, pout8[o*DW +: DW]);
        end else begin
          e = q8.pop_front();
          if (pout8[o*DW +: DW] !== e) begin
            n_bad++;
            $display("FAIL sb8_out4: got %h wanted %h", pout8[o*DW +: DW], e);
          end
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int p, input logic [63:0] f, input int op);
    pin[p*DW +: DW] = f;
    si[p] = 1'b1;
    for (int t = 0; t < 40 && !ri[p]; t++) tick();
    n_total++;
    if (!ri[p]) begin
      n_bad++;
      $display("FAIL send_in%0d: ri stuck at 0, wanted 1", p);
    end else begin
      if (op >= 0) q[op].push_back(f);
      tick();
    end
    si[p] = 1'b0;
  endtask

  task automatic send8(input int p, input logic [63:0] f);
    pin8[p*DW +: DW] = f;
    si8[p] = 1'b1;
    for (int t = 0; t < 40 && !ri8[p]; t++) tick();
    n_total++;
    if (!ri8[p]) begin
      n_bad++;
      $display("FAIL send8_in%0d: ri stuck at 0, wanted 1", p);
    end else begin
      q8.push_back(f);
      tick();
    end
    si8[p] = 1'b0;
  endtask

  task automatic drain(input int budget);
    for (int t = 0; t < budget && pending() != 0; t++) tick();
    n_total++;
    if (pending() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d flits still pending, wanted 0", pending());
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    si = '0; si8 = '0; pin = '0; pin8 = '0; ro = 5'h1F; ro8 = 5'h1F;
    for (int o = 0; o < 5; o++) q[o].delete();
    q8.delete();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    si = '0; si8 = '0; pin = '0; pin8 = '0; ro = 5'h1F; ro8 = 5'h1F;
    #7;
    n_total++; if (so !== 5'h00)    begin n_bad++; $display("FAIL rst_so: got %h wanted 00", so); end
    n_total++; if (pout !== '0)     begin n_bad++; $display("FAIL rst_pout: got %h wanted 0", pout); end
    n_total++; if (dcnt !== 16'h0)  begin n_bad++; $display("FAIL rst_dcnt: got %h wanted 0", dcnt); end
    n_total++; if (pol !== 1'b0)    begin n_bad++; $display("FAIL rst_pol: got %b wanted 0", pol); end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    n_total++; if (ri !== 5'h1F)    begin n_bad++; $display("FAIL rst_ri: got %h wanted 1f", ri); end
    for (int i = 0; i < 4; i++) begin
      n_total++;
      if (pol !== 1'((i + 1) & 1)) begin
        n_bad++; $display("FAIL pol_toggle%0d: got %b wanted %0d", i, pol, (i + 1) & 1);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    ro = 5'h1E;
    send(0, mk(3, 1, 56'hD0), -1);
    for (int i = 0; i < 3; i++) send(1, mk(2, 1, 56'hA0 + 56'(i)), 0);
    n_total++; if (so[0] !== 1'b1)   begin n_bad++; $display("FAIL mid_pre_so: got %b wanted 1", so[0]); end
    n_total++; if (dcnt !== 16'd1)   begin n_bad++; $display("FAIL mid_pre_dcnt: got %0d wanted 1", dcnt); end
    #3;
    reset = 1'b0;
    #1;
    n_total++; if (so !== 5'h00)     begin n_bad++; $display("FAIL mid_so: got %h wanted 00", so); end
    n_total++; if (pout !== '0)      begin n_bad++; $display("FAIL mid_pout: got %h wanted 0", pout); end
    n_total++; if (dcnt !== 16'h0)   begin n_bad++; $display("FAIL mid_dcnt: got %h wanted 0", dcnt); end
    n_total++; if (pol !== 1'b0)     begin n_bad++; $display("FAIL mid_pol: got %b wanted 0", pol); end
    for (int o = 0; o < 5; o++) q[o].delete();
    ro = 5'h1F;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    n_total++; if (ri !== 5'h1F)     begin n_bad++; $display("FAIL mid_ri: got %h wanted 1f", ri); end
    for (int i = 0; i < 6; i++) tick();
  endtask

  task automatic test_route();
    int          t_in [8] = '{1, 0, 4, 2, 3, 4, 0, 1};
    int          t_x  [8] = '{1, 0, 2, 1, 1, 1, 1, 5};
    int          t_y  [8] = '{1, 1, 1, 3, 0, 0, 2, 0};
    int          t_out[8] = '{4, 1, 0, 3, 2, 2, 3, 0};
    logic [63:0] f;
    do_reset();
    f = mk(2, 1, 56'hC0FFEE);
    pin[1*DW +: DW] = f;
    si[1] = 1'b1;
    q[0].push_back(f);
    tick();
    si[1] = 1'b0;
    n_total++; if (so[0] !== 1'b0)   begin n_bad++; $display("FAIL lat_early: got so0=%b wanted 0", so[0]); end
    tick();
    n_total++; if (so[0] !== 1'b1)   begin n_bad++; $display("FAIL lat_so: got so0=%b wanted 1", so[0]); end
    n_total++; if (pout[63:0] !== f) begin n_bad++; $display("FAIL lat_data: got %h wanted %h", pout[63:0], f); end
    drain(10);
    for (int i = 0; i < 8; i++) begin
      send(t_in[i], mk(4'(t_x[i]), 4'(t_y[i]), 56'h100 + 56'(i)), t_out[i]);
      drain(20);
    end
  endtask

  task automatic test_contention();
    do_reset();
    for (int p = 0; p < 5; p++) pin[p*DW +: DW] = mk(1, 0, 56'h200 + 56'(p));
    q[2].push_back(mk(1, 0, 56'h200));
    q[2].push_back(mk(1, 0, 56'h201));
    q[2].push_back(mk(1, 0, 56'h203));
    q[2].push_back(mk(1, 0, 56'h204));
    si = 5'b11011;
    tick();
    si = '0;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_total++;
      if (so[2] !== 1'b1) begin n_bad++; $display("FAIL cont_busy%0d: got so2=%b wanted 1", i, so[2]); end
    end
    drain(10);
    // Pointer now sits on PE, so E outranks PE again.
    pin[4*DW +: DW] = mk(1, 0, 56'h214);
    pin[0*DW +: DW] = mk(1, 0, 56'h210);
    q[2].push_back(mk(1, 0, 56'h210));
    q[2].push_back(mk(1, 0, 56'h214));
    si = 5'b10001;
    tick();
    si = '0;
    drain(10);
  endtask

  task automatic test_backpressure();
    logic [63:0] f6;
    do_reset();
    ro = 5'h1E;
    for (int i = 0; i < 5; i++) send(1, mk(2, 1, 56'h300 + 56'(i)), 0);
    f6 = mk(2, 1, 56'h305);
    pin[1*DW +: DW] = f6;
    si[1] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      n_total++; if (ri[1] !== 1'b0) begin n_bad++; $display("FAIL bp_ri%0d: got %b wanted 0", i, ri[1]); end
      n_total++; if (so[0] !== 1'b1) begin n_bad++; $display("FAIL bp_so%0d: got %b wanted 1", i, so[0]); end
      n_total++;
      if (pout[63:0] !== mk(2, 1, 56'h300)) begin
        n_bad++; $display("FAIL bp_hold%0d: got %h wanted %h", i, pout[63:0], mk(2, 1, 56'h300));
      end
      tick();
    end
    ro = 5'h1F;
    send(1, f6, 0);
    drain(20);
  endtask

  task automatic test_simul();
    logic [63:0] f5;
    do_reset();
    ro = 5'h1E;
    for (int i = 0; i < 4; i++) send(1, mk(2, 1, 56'h400 + 56'(i)), 0);
    n_total++; if (ri[1] !== 1'b1) begin n_bad++; $display("FAIL sim_ri_pre: got %b wanted 1", ri[1]); end
    f5 = mk(2, 1, 56'h404);
    pin[1*DW +: DW] = f5;
    si[1] = 1'b1;
    ro[0] = 1'b1;
    q[0].push_back(f5);
    tick();
    si[1] = 1'b0;
    ro[0] = 1'b0;
    n_total++; if (ri[1] !== 1'b1) begin n_bad++; $display("FAIL sim_ri_post: got %b wanted 1", ri[1]); end
    send(1, mk(2, 1, 56'h405), 0);
    n_total++; if (ri[1] !== 1'b0) begin n_bad++; $display("FAIL sim_full: got %b wanted 0", ri[1]); end
    ro = 5'h1F;
    drain(20);
  endtask

  task automatic test_illegal();
    do_reset();
    send(0, mk(3, 1, 56'h500), -1);
    tick();
    n_total++; if (dcnt !== 16'd1) begin n_bad++; $display("FAIL drop_e: got %0d wanted 1", dcnt); end
    n_total++; if (so !== 5'h00)   begin n_bad++; $display("FAIL drop_so: got %h wanted 00", so); end
    send(4, mk(1, 1, 56'h501), -1);
    tick();
    n_total++; if (dcnt !== 16'd2) begin n_bad++; $display("FAIL drop_pe: got %0d wanted 2", dcnt); end
    do_reset();
    pin[0*DW +: DW] = mk(3, 1, 56'h0);
    pin[1*DW +: DW] = mk(0, 1, 56'h1);
    pin[2*DW +: DW] = mk(1, 0, 56'h2);
    pin[3*DW +: DW] = mk(1, 2, 56'h3);
    pin[4*DW +: DW] = mk(1, 1, 56'h4);
    si = 5'h1F;
    tick();
    tick();
    n_total++; if (dcnt !== 16'd5)  begin n_bad++; $display("FAIL drop_x5: got %0d wanted 5", dcnt); end
    tick();
    n_total++; if (dcnt !== 16'd10) begin n_bad++; $display("FAIL drop_x10: got %0d wanted 10", dcnt); end
    for (int i = 0; i < 13110; i++) tick();
    n_total++; if (dcnt !== 16'hFFFF) begin n_bad++; $display("FAIL drop_sat: got %h wanted ffff", dcnt); end
    for (int i = 0; i < 20; i++) tick();
    n_total++; if (dcnt !== 16'hFFFF) begin n_bad++; $display("FAIL drop_hold: got %h wanted ffff", dcnt); end
    si = '0;
  endtask

  task automatic test_wrap8();
    do_reset();
    ro8 = 5'h0F;
    for (int i = 0; i < 9; i++) send8(1, mk(1, 1, 56'h600 + 56'(i)));
    n_total++; if (ri8[1] !== 1'b0) begin n_bad++; $display("FAIL d8_full: got %b wanted 0", ri8[1]); end
    ro8 = 5'h1F;
    for (int i = 9; i < 14; i++) send8(1, mk(1, 1, 56'h600 + 56'(i)));
    drain(40);
  endtask

  initial begin
    test_reset();
    test_reset_mid();
    test_route();
    test_contention();
    test_backpressure();
    test_simul();
    test_illegal();
    test_wrap8();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
